// File: rtl/vga_timing_pkg.sv
// Shared 640x480 mode constants, receiver FSM states and a small saturating helper,
// used by both the pixel-timing generator and the receiver.
package vga_timing_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned HFront  = 16;
  localparam int unsigned HSync   = 96;
  localparam int unsigned HBack   = 48;
  localparam int unsigned HTotal  = HActive + HFront + HSync + HBack;

  localparam int unsigned VActive = 480;
  localparam int unsigned VFront  = 10;
  localparam int unsigned VSync   = 2;
  localparam int unsigned VBack   = 33;
  localparam int unsigned VTotal  = VActive + VFront + VSync + VBack;

  typedef enum logic [1:0] {
    StSearch,
    StCheck,
    StLocked
  } rx_state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one timing input, keeps a delayed copy and flags the transition into
// the active level (POL gives the active level).
module vga_sync_edge #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic level,
  output logic rise
);

  logic sig_q, sig_dly_q;

  // Reset to the inactive level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q     <= ~POL;
      sig_dly_q <= ~POL;
    end else begin
      sig_q     <= sig;
      sig_dly_q <= sig_q;
    end
  end

  assign level = (sig_q == POL);
  assign rise  = (sig_q == POL) && (sig_dly_q != POL);

endmodule

// File: rtl/vga_timing_rx.sv
// Sink side of the VGA timing interface: recovers pixel position, measures line and
// frame length, and tracks lock against the expected mode.
module vga_timing_rx
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = HTotal,
  parameter int unsigned V_TOTAL     = VTotal,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  output logic [9:0] rx_sx,
  output logic [9:0] rx_sy,
  output logic       rx_de,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [10:0] Timeout  = 11'(2 * H_TOTAL);
  localparam logic [9:0]  HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  HExp     = 10'(H_TOTAL);
  localparam logic [9:0]  VExp     = 10'(V_TOTAL);
  localparam logic [3:0]  LockGood = 4'(LOCK_FRAMES);

  logic hs_act, vs_act, de_q, hs_edge, vs_edge, de_rise;

  vga_sync_edge #(.POL(HS_POL)) u_hs (
    .clk(clk), .reset(reset), .sig(hsync_in), .level(hs_act), .rise(hs_edge)
  );
  vga_sync_edge #(.POL(VS_POL)) u_vs (
    .clk(clk), .reset(reset), .sig(vsync_in), .level(vs_act), .rise(vs_edge)
  );
  vga_sync_edge #(.POL(1'b1)) u_de (
    .clk(clk), .reset(reset), .sig(de_in), .level(de_q), .rise(de_rise)
  );

  logic unused_act;
  assign unused_act = hs_act ^ vs_act;

  rx_state_e   state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [10:0] h_cnt_q, h_len;
  logic [9:0]  v_cnt_q, line_cap, frame_cap;
  logic        frame_start_q, meas_valid_q, meas_valid_d, lines_ok_q;
  logic        timeout, line_bad, frame_ok, loss;

  // h_cnt runs past 1023 so the 2-line timeout stays reachable; line_len still saturates.
  assign h_len     = h_cnt_q + 11'd1;
  assign line_cap  = (h_len > 11'd1023) ? 10'd1023 : h_len[9:0];
  assign frame_cap = hs_edge ? sat_inc10(v_cnt_q) : v_cnt_q;
  assign timeout   = (h_cnt_q >= Timeout);
  assign line_bad  = hs_edge && meas_valid_q && (line_cap != HExp);
  assign frame_ok  = lines_ok_q && !line_bad && (frame_cap == VExp);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    loss    = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (vs_edge) begin
          state_d = StCheck;
          good_d  = '0;
        end
      end
      StCheck: begin
        if (timeout) begin
          state_d = StSearch;
        end else if (vs_edge) begin
          if (frame_ok) begin
            good_d = good_q + 4'd1;
            if (good_d >= LockGood) state_d = StLocked;
          end else begin
            good_d = '0;
          end
        end
      end
      StLocked: begin
        if (line_bad || timeout || (vs_edge && !frame_ok)) begin
          state_d = StSearch;
          loss    = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // The first hsync edge after (re)entering search only arms the line measurement.
  always_comb begin
    meas_valid_d = meas_valid_q;
    if (state_d == StSearch && state_q != StSearch) meas_valid_d = 1'b0;
    else if (hs_edge)                               meas_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StSearch;
      good_q        <= '0;
      locked        <= 1'b0;
      err           <= 1'b0;
      err_count     <= '0;
      rx_sx         <= '0;
      rx_sy         <= '0;
      rx_de         <= 1'b0;
      frame_start_q <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len      <= '0;
      frame_lines   <= '0;
      meas_valid_q  <= 1'b0;
      lines_ok_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      locked       <= (state_d == StLocked);
      err          <= loss;
      meas_valid_q <= meas_valid_d;
      if (loss && err_count != 8'hff) err_count <= err_count + 8'd1;

      rx_de <= de_q;
      if (de_rise)             rx_sx <= '0;
      else if (rx_sx == HLast) rx_sx <= '0;
      else                     rx_sx <= rx_sx + 10'd1;

      if (de_rise) rx_sy <= frame_start_q ? 10'd0 : sat_inc10(rx_sy);
      if (vs_edge)      frame_start_q <= 1'b1;
      else if (de_rise) frame_start_q <= 1'b0;

      if (hs_edge) begin
        line_len <= line_cap;
        h_cnt_q  <= '0;
      end else if (!timeout) begin
        h_cnt_q  <= h_len;
      end

      if (vs_edge) begin
        frame_lines <= frame_cap;
        v_cnt_q     <= '0;
        lines_ok_q  <= 1'b1;
      end else begin
        if (hs_edge)  v_cnt_q    <= sat_inc10(v_cnt_q);
        if (line_bad) lines_ok_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench: a small-mode timing generator drives the receiver; a delay-line
// scoreboard checks recovered positions and directed steps check lock/err behaviour.
module tb_vga_timing_rx;

  localparam int unsigned HT = 40;
  localparam int unsigned VT = 20;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
  } pos_t;

  logic       clk, rst, gen_rst;
  logic       force_hs, force_vs, force_de;
  logic [9:0] gen_hmax, gen_sx, gen_sy;
  logic       gen_hs, gen_vs, gen_de;
  logic       hsync_in, vsync_in, de_in;
  logic [9:0] rx_sx, rx_sy, line_len, frame_lines;
  logic       rx_de, locked, err;
  logic [7:0] err_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_cycles = 0;
  pos_t sb[$];
  pos_t push_p, exp_p;

  vga_timing_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .rx_sx(rx_sx), .rx_sy(rx_sy), .rx_de(rx_de), .locked(locked), .line_len(line_len),
    .frame_lines(frame_lines), .err(err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator: 32 active + 2 fp + 4 sync + 2 bp clocks; 16 active + 1 fp + 2 sync + 1 bp lines.
  always @(posedge clk) begin
    if (gen_rst) begin
      gen_sx <= '0;
      gen_sy <= '0;
    end else if (gen_sx == gen_hmax) begin
      gen_sx <= '0;
      gen_sy <= (gen_sy == 10'(VT - 1)) ? 10'd0 : gen_sy + 10'd1;
    end else begin
      gen_sx <= gen_sx + 10'd1;
    end
  end

  assign gen_hs   = !((gen_sx >= 10'd34) && (gen_sx < 10'd38));
  assign gen_vs   = !((gen_sy >= 10'd17) && (gen_sy < 10'd19));
  assign gen_de   = (gen_sx < 10'd32) && (gen_sy < 10'd16);
  assign hsync_in = force_hs ? 1'b1 : gen_hs;
  assign vsync_in = force_vs ? 1'b1 : gen_vs;
  assign de_in    = force_de ? 1'b0 : gen_de;

  // Scoreboard push: what the generator presented in the cycle just ending.
  always @(posedge clk) begin
    push_p = {gen_sx, gen_sy, gen_de};
    sb.push_back(push_p);
    if (sb.size() > 8) void'(sb.pop_front());
  end

  always @(negedge clk) if (err === 1'b1) err_cycles++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_sx"}, rx_sx, 0);
    chk({tag, "_rx_sy"}, rx_sy, 0);
    chk({tag, "_rx_de"}, rx_de, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  // Returns two clocks after the vsync assertion reaches the input, when its effects are visible.
  task automatic wait_vs();
    logic prev, found;
    int   n;
    prev  = vsync_in;
    found = 1'b0;
    n     = 0;
    while (!found && n < 2000) begin
      @(negedge clk);
      n++;
      if (prev && !vsync_in) found = 1'b1;
      prev = vsync_in;
    end
    chk("vs_wait", found, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_line(input logic [9:0] sy);
    logic found;
    int   n;
    found = 1'b0;
    n     = 0;
    while (!found && n < 2000) begin
      @(negedge clk);
      n++;
      if (gen_sx == 10'd0 && gen_sy == sy) found = 1'b1;
    end
    chk("line_wait", found, 1);
  endtask

  task automatic check_positions(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      while (sb.size() > 1) exp_p = sb.pop_front();
      chk("rx_de", rx_de, exp_p.de);
      chk("rx_sx", rx_sx, exp_p.sx);
      if (exp_p.de) chk("rx_sy", rx_sy, exp_p.sy);
    end
  endtask

  initial begin
    logic found;
    force_hs = 1'b0;
    force_vs = 1'b0;
    force_de = 1'b0;
    gen_hmax = 10'(HT - 1);
    rst      = 1'b1;
    gen_rst  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("init");
    rst     = 1'b0;
    gen_rst = 1'b0;

    // Lock exactly at the third vsync assertion.
    wait_vs();
    wait_vs();
    chk("lock_early", locked, 0);
    wait_vs();
    chk("lock_3rd", locked, 1);
    chk("line_len", line_len, HT);
    chk("frame_lines", frame_lines, VT);
    check_positions(2 * HT * VT);
    chk("no_err", err_cycles, 0);
    chk("err_count0", err_count, 0);

    // One line with hsync held inactive: the 80-clock line is judged bad.
    wait_line(10'd3);
    force_hs = 1'b1;
    repeat (HT) @(negedge clk);
    force_hs = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (err === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    chk("hs_err_seen", found, 1);
    chk("hs_locked", locked, 0);
    chk("hs_err_count", err_count, 1);
    chk("hs_line_len", line_len, 2 * HT);
    @(negedge clk);
    chk("hs_err_1cyc", err, 0);
    wait_vs();
    wait_vs();
    wait_vs();
    chk("hs_relock", locked, 1);
    chk("hs_err_cycles", err_cycles, 1);

    // All inputs inactive for two lines: timeout drops lock.
    wait_line(10'd2);
    force_hs = 1'b1;
    force_vs = 1'b1;
    force_de = 1'b1;
    repeat (2 * HT) @(negedge clk);
    force_hs = 1'b0;
    force_vs = 1'b0;
    force_de = 1'b0;
    chk("to_locked", locked, 0);
    chk("to_err_count", err_count, 2);
    chk("to_err_cycles", err_cycles, 2);
    wait_vs();
    chk("to_frame_lines", frame_lines, VT - 2);
    wait_vs();
    wait_vs();
    chk("to_relock", locked, 1);
    chk("to_frame_lines2", frame_lines, VT);

    // One missing vsync: a 40-line frame is a bad frame.
    wait_line(10'd0);
    force_vs = 1'b1;
    repeat (HT * VT) @(negedge clk);
    force_vs = 1'b0;
    wait_vs();
    chk("vs_frame_lines", frame_lines, 2 * VT);
    chk("vs_err", err, 1);
    chk("vs_locked", locked, 0);
    chk("vs_err_count", err_count, 3);

    // 42-clock lines never lock and never raise err.
    rst      = 1'b1;
    gen_rst  = 1'b1;
    gen_hmax = 10'(HT + 1);
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    gen_rst = 1'b0;
    repeat (4) wait_vs();
    chk("long_line_len", line_len, HT + 2);
    chk("long_frame_lines", frame_lines, VT);
    chk("long_locked", locked, 0);
    chk("long_err_count", err_count, 0);
    chk("long_err_cycles", err_cycles, 3);

    // Mid-frame reset of the receiver only.
    rst      = 1'b1;
    gen_rst  = 1'b1;
    gen_hmax = 10'(HT - 1);
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    gen_rst = 1'b0;
    repeat (3) wait_vs();
    chk("mid_pre_lock", locked, 1);
    wait_line(10'd5);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid");
    rst = 1'b0;
    wait_vs();
    wait_vs();
    chk("mid_lock_early", locked, 0);
    wait_vs();
    chk("mid_relock", locked, 1);
    check_positions(HT * VT);
    chk("mid_err_cycles", err_cycles, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
